// File: rtl/traffic_light_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// traffic_light_pkg : shared encodings for the traffic light monitor
// Revision: 1.0
// ---------------------------------------------------------------------------
package traffic_light_pkg;

  localparam logic [1:0] PH_RED    = 2'b00;
  localparam logic [1:0] PH_GREEN  = 2'b01;
  localparam logic [1:0] PH_YELLOW = 2'b10;
  localparam logic [1:0] PH_NONE   = 2'b11;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  localparam logic [2:0] FLT_NONE     = 3'd0;
  localparam logic [2:0] FLT_ILLEGAL  = 3'd1;
  localparam logic [2:0] FLT_SEQUENCE = 3'd2;
  localparam logic [2:0] FLT_SHORT    = 3'd3;
  localparam logic [2:0] FLT_LONG     = 3'd4;

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_RED    = 3'd1,
    ST_GREEN  = 3'd2,
    ST_YELLOW = 3'd3,
    ST_FAULT  = 3'd4
  } mon_state_t;

  // Minimum dwell clamps at zero when the tolerance exceeds the nominal time.
  function automatic int dwell_min(input int cycles, input int tol);
    return (cycles > tol) ? (cycles - tol) : 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl_dwell_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tl_dwell_counter : saturating phase dwell counter with short/long compares
// Revision: 1.0
// ---------------------------------------------------------------------------
module tl_dwell_counter #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic [CNT_W-1:0] min_val,
  input  logic [CNT_W-1:0] max_val,
  output logic             is_short,
  output logic             is_long
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W:0]   w_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  // One extra bit so the long compare stays true once the count saturates.
  assign w_next   = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
  assign is_short = (r_count < min_val);
  assign is_long  = (w_next > {1'b0, max_val});

endmodule
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// traffic_light_monitor : one-hot, ordering and dwell checker for the lights bus
// Revision: 1.0
// ---------------------------------------------------------------------------
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = 6,
  parameter int GREEN_CYCLES  = 6,
  parameter int YELLOW_CYCLES = 3,
  parameter int TOL           = 0,
  parameter int CNT_W         = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  lights,
  input  logic        clr_fault,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic        fail_safe,
  output logic [1:0]  phase,
  output logic        phase_done,
  output logic [15:0] cycles_done
);

  localparam logic [CNT_W-1:0] C_RED_MIN = CNT_W'(dwell_min(RED_CYCLES, TOL));
  localparam logic [CNT_W-1:0] C_RED_MAX = CNT_W'(RED_CYCLES + TOL);
  localparam logic [CNT_W-1:0] C_GRN_MIN = CNT_W'(dwell_min(GREEN_CYCLES, TOL));
  localparam logic [CNT_W-1:0] C_GRN_MAX = CNT_W'(GREEN_CYCLES + TOL);
  localparam logic [CNT_W-1:0] C_YEL_MIN = CNT_W'(dwell_min(YELLOW_CYCLES, TOL));
  localparam logic [CNT_W-1:0] C_YEL_MAX = CNT_W'(YELLOW_CYCLES + TOL);

  mon_state_t       r_state;
  logic             r_first;
  logic             r_fault;
  logic [2:0]       r_code;
  logic [1:0]       r_phase;
  logic             r_phase_done;
  logic [15:0]      r_cycles;

  logic [2:0]       w_cur_lt;
  logic [2:0]       w_succ_lt;
  mon_state_t       w_succ_st;
  logic [1:0]       w_succ_ph;
  logic [CNT_W-1:0] w_min;
  logic [CNT_W-1:0] w_max;
  logic             w_in_phase;
  logic             w_onehot;
  logic             w_short_bad;
  logic             w_load;
  logic             w_inc;
  logic             w_is_short;
  logic             w_is_long;

  always_comb begin
    w_cur_lt  = LT_RED;
    w_succ_lt = LT_GRN;
    w_succ_st = ST_GREEN;
    w_succ_ph = PH_GREEN;
    w_min     = C_RED_MIN;
    w_max     = C_RED_MAX;
    case (r_state)
      ST_GREEN: begin
        w_cur_lt  = LT_GRN;
        w_succ_lt = LT_YEL;
        w_succ_st = ST_YELLOW;
        w_succ_ph = PH_YELLOW;
        w_min     = C_GRN_MIN;
        w_max     = C_GRN_MAX;
      end
      ST_YELLOW: begin
        w_cur_lt  = LT_YEL;
        w_succ_lt = LT_RED;
        w_succ_st = ST_RED;
        w_succ_ph = PH_RED;
        w_min     = C_YEL_MIN;
        w_max     = C_YEL_MAX;
      end
      default: ;
    endcase
  end

  assign w_in_phase  = (r_state == ST_RED) || (r_state == ST_GREEN) || (r_state == ST_YELLOW);
  assign w_onehot    = $onehot(lights);
  // The first RED after sync may have been entered mid-phase, so it is never short.
  assign w_short_bad = w_is_short && !r_first;
  assign w_load      = ((r_state == ST_SYNC) && (lights == LT_RED)) ||
                       (w_in_phase && (lights == w_succ_lt) && !w_short_bad);
  assign w_inc       = w_in_phase && (lights == w_cur_lt);

  tl_dwell_counter #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .inc      (w_inc),
    .min_val  (w_min),
    .max_val  (w_max),
    .is_short (w_is_short),
    .is_long  (w_is_long)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_SYNC;
      r_first      <= 1'b0;
      r_fault      <= 1'b0;
      r_code       <= FLT_NONE;
      r_phase      <= PH_NONE;
      r_phase_done <= 1'b0;
      r_cycles     <= 16'd0;
    end else begin
      r_phase_done <= 1'b0;
      case (r_state)
        ST_SYNC: begin
          if (lights == LT_RED) begin
            r_state <= ST_RED;
            r_phase <= PH_RED;
            r_first <= 1'b1;
          end
        end
        ST_RED, ST_GREEN, ST_YELLOW: begin
          if (!w_onehot) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
            r_code  <= FLT_ILLEGAL;
            r_phase <= PH_NONE;
          end else if (lights == w_cur_lt) begin
            if (w_is_long) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
              r_code  <= FLT_LONG;
              r_phase <= PH_NONE;
            end
          end else if (lights == w_succ_lt) begin
            if (w_short_bad) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
              r_code  <= FLT_SHORT;
              r_phase <= PH_NONE;
            end else begin
              r_state      <= w_succ_st;
              r_phase      <= w_succ_ph;
              r_phase_done <= 1'b1;
              r_first      <= 1'b0;
              if ((r_state == ST_YELLOW) && (r_cycles != 16'hFFFF)) begin
                r_cycles <= r_cycles + 16'd1;
              end
            end
          end else begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
            r_code  <= FLT_SEQUENCE;
            r_phase <= PH_NONE;
          end
        end
        ST_FAULT: begin
          if (clr_fault) begin
            r_state <= ST_SYNC;
            r_fault <= 1'b0;
            r_code  <= FLT_NONE;
            r_phase <= PH_NONE;
          end
        end
        default: begin
          r_state <= ST_SYNC;
          r_phase <= PH_NONE;
        end
      endcase
    end
  end

  assign fault       = r_fault;
  assign fault_code  = r_code;
  assign fail_safe   = r_fault;
  assign phase       = r_phase;
  assign phase_done  = r_phase_done;
  assign cycles_done = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_traffic_light_monitor : directed vectors for traffic_light_monitor
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  lights;
  logic        clr_fault;

  logic        fault, fail_safe, phase_done;
  logic [2:0]  fault_code;
  logic [1:0]  phase;
  logic [15:0] cycles_done;

  logic        fault_t, fail_safe_t, phase_done_t;
  logic [2:0]  fault_code_t;
  logic [1:0]  phase_t;
  logic [15:0] cycles_done_t;

  int n_vec = 0;
  int n_err = 0;
  int pulses;
  int faults_seen;

  always #5 clk = ~clk;

  traffic_light_monitor dut (
    .clk(clk), .reset(reset), .lights(lights), .clr_fault(clr_fault),
    .fault(fault), .fault_code(fault_code), .fail_safe(fail_safe),
    .phase(phase), .phase_done(phase_done), .cycles_done(cycles_done)
  );

  traffic_light_monitor #(.TOL(2)) dut_tol (
    .clk(clk), .reset(reset), .lights(lights), .clr_fault(clr_fault),
    .fault(fault_t), .fault_code(fault_code_t), .fail_safe(fail_safe_t),
    .phase(phase_t), .phase_done(phase_done_t), .cycles_done(cycles_done_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [2:0] v);
    lights = v;
    @(posedge clk);
    #1;
    if (phase_done) pulses++;
    if (fault) faults_seen++;
  endtask

  task automatic apply_n(input logic [2:0] v, input int n);
    for (int i = 0; i < n; i++) apply(v);
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    lights    = 3'b000;
    clr_fault = 1'b0;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    pulses      = 0;
    faults_seen = 0;
  endtask

  initial begin
    do_reset();
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_code", {29'd0, fault_code}, 32'd0);
    check("rst_failsafe", {31'd0, fail_safe}, 32'd0);
    check("rst_phase", {30'd0, phase}, 32'd3);
    check("rst_pdone", {31'd0, phase_done}, 32'd0);
    check("rst_cycles", {16'd0, cycles_done}, 32'd0);

    // Three nominal cycles then RED
    apply_n(3'b000, 2);
    check("sync_ignore", {30'd0, phase}, 32'd3);
    for (int p = 0; p < 3; p++) begin
      apply_n(R, 6);
      apply_n(G, 6);
      apply_n(Y, 3);
    end
    apply(R);
    check("nom_pulses", pulses, 32'd9);
    check("nom_faults", faults_seen, 32'd0);
    check("nom_cycles", {16'd0, cycles_done}, 32'd3);
    check("nom_phase", {30'd0, phase}, 32'd0);

    // Illegal pattern mid-GREEN
    do_reset();
    apply_n(R, 6);
    apply_n(G, 3);
    check("ill_pre_phase", {30'd0, phase}, 32'd1);
    apply(3'b110);
    check("ill_fault", {31'd0, fault}, 32'd1);
    check("ill_code", {29'd0, fault_code}, 32'd1);
    check("ill_failsafe", {31'd0, fail_safe}, 32'd1);
    check("ill_phase", {30'd0, phase}, 32'd3);

    // Out-of-order, then a later fault does not overwrite the code
    do_reset();
    apply_n(R, 6);
    apply(Y);
    check("seq_code", {29'd0, fault_code}, 32'd2);
    apply(3'b000);
    check("seq_sticky", {29'd0, fault_code}, 32'd2);
    check("seq_cycles_held", {16'd0, cycles_done}, 32'd0);

    // Short GREEN; tolerant instance accepts it
    do_reset();
    apply_n(R, 6);
    apply_n(G, 4);
    apply(Y);
    check("short_code", {29'd0, fault_code}, 32'd3);
    check("short_tol_fault", {31'd0, fault_t}, 32'd0);
    check("short_tol_phase", {30'd0, phase_t}, 32'd2);
    check("short_tol_pdone", {31'd0, phase_done_t}, 32'd1);

    // First RED after sync is exempt from the short check
    do_reset();
    apply_n(R, 2);
    apply(G);
    check("first_red_fault", {31'd0, fault}, 32'd0);
    check("first_red_phase", {30'd0, phase}, 32'd1);

    // Long YELLOW
    do_reset();
    apply_n(R, 6);
    apply_n(G, 6);
    apply_n(Y, 3);
    check("yel3_fault", {31'd0, fault}, 32'd0);
    apply(Y);
    check("yel4_code", {29'd0, fault_code}, 32'd4);

    // Stuck at RED
    do_reset();
    apply_n(R, 6);
    check("red6_fault", {31'd0, fault}, 32'd0);
    apply(R);
    check("red7_code", {29'd0, fault_code}, 32'd4);

    // Clear from FAULT; stays unsynced until RED
    clr_fault = 1'b1;
    apply(G);
    clr_fault = 1'b0;
    check("clr_fault", {31'd0, fault}, 32'd0);
    check("clr_code", {29'd0, fault_code}, 32'd0);
    check("clr_phase", {30'd0, phase}, 32'd3);
    apply(G);
    apply(Y);
    apply(3'b000);
    check("clr_unsync_phase", {30'd0, phase}, 32'd3);
    check("clr_unsync_fault", {31'd0, fault}, 32'd0);
    apply(R);
    check("clr_resync", {30'd0, phase}, 32'd0);

    // clr_fault outside FAULT is ignored and cannot mask a new fault
    do_reset();
    apply(R);
    clr_fault = 1'b1;
    apply(R);
    check("clr_idle_phase", {30'd0, phase}, 32'd0);
    apply(3'b000);
    check("clr_same_edge", {29'd0, fault_code}, 32'd1);
    clr_fault = 1'b0;

    // Asynchronous reset mid-GREEN
    do_reset();
    apply_n(R, 6);
    apply_n(G, 6);
    apply_n(Y, 3);
    apply_n(R, 6);
    apply_n(G, 3);
    check("pre_rst_cycles", {16'd0, cycles_done}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_phase", {30'd0, phase}, 32'd3);
    check("arst_cycles", {16'd0, cycles_done}, 32'd0);
    check("arst_fault", {31'd0, fault}, 32'd0);
    check("arst_pdone", {31'd0, phase_done}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
